pts_sequencer: RTL and testbench
================================

# pts_sequencer

Column scheduler that feeds the byte-serial AES datapath through the parallel-to-serial converter. Accepts one 128-bit state block via a valid/ready handshake and splits it into four 32-bit columns. Presents each column on d0..d3 with a one-cycle load strobe (wired to the converter's `en`), then counts out the four byte slots. Sits between the block-level input register and `pts_converter`; it owns all converter sequencing.

## Interface
Parameters:
- none; the column count (4) and bytes per column (4) are fixed by AES.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `in_data` holds a block to transfer.
- `in_ready`  out  1  sequencer can accept a block this cycle.
- `in_data`  in  128  state block; byte 0 = `in_data[127:120]` … byte 15 = `in_data[7:0]`.
- `abort`  in  1  synchronous cancel of the current block.
- `col_ld`  out  1  one-cycle load strobe to the converter `en`.
- `d0`,`d1`,`d2`,`d3`  out  8 each  current column bytes, stable for the whole column window.
- `col_idx`  out  2  current column, 0..3.
- `byte_idx`  out  2  current byte slot within the column, 0..3.
- `busy`  out  1  block in flight.
- `done`  out  1  one-cycle pulse after the last byte slot.
- `out_ready`  in  1  sink can advance; present only with `PTS_SEQ_STALL_EN`.

## Operation
- Column c drives d0..d3 = block bytes 4c, 4c+1, 4c+2, 4c+3.
- States:
  - IDLE: `in_ready`=1. Handshake (`in_valid`&`in_ready`) captures `in_data` into a 128-bit block register, clears the 4-bit count `cnt`, and moves to RUN.
  - RUN: `col_idx`=`cnt[3:2]`, `byte_idx`=`cnt[1:0]`, `busy`=1, `in_ready`=0.
    - `col_ld`=1 when `byte_idx`==0, giving exactly one strobe per column.
    - `cnt` increments each cycle.
    - At `cnt`==15, go to DONE.
  - DONE (one cycle): `done`=1, `busy`=0, `in_ready`=1.
    - A handshake here goes straight to RUN (back-to-back blocks).
    - Otherwise go to IDLE.
- `abort` in RUN or DONE: return to IDLE next cycle, clear `cnt`, no `done` pulse. d0..d3 keep their last value.
- `abort` together with `in_valid` in IDLE or DONE: `abort` wins and no block is accepted.
- `in_data` is sampled only on the handshake cycle; later changes to `in_data` are ignored.

## Timing
- Reset values (`rst` low, asynchronous):
  - State = IDLE, `cnt`=0, block register=0.
  - `in_ready`=0, `col_ld`=0, d0..d3=0, `col_idx`=0, `byte_idx`=0, `busy`=0, `done`=0.
- `in_ready` is registered. It rises on the first rising edge after `rst` is released.
- Handshake at edge k:
  - `col_ld`=1 and column 0 appear on d0..d3 in the cycle after edge k.
  - Columns 1, 2, 3 follow at offsets +4, +8, +12 cycles.
  - `done`=1 at offset +16.
- Throughput: 17 cycles per block back-to-back (16 RUN cycles + 1 DONE cycle). The handshake is taken in DONE.
- `rst` asserted mid-RUN: all outputs go to their reset values immediately. The partial block is discarded.
- d0..d3, `col_idx`, `byte_idx`, `col_ld`, `busy` and `done` are registered outputs. `in_ready` is registered.

## Configuration
- `PTS_SEQ_STALL_EN` defined:
  - Adds the `out_ready` input.
  - In RUN, `cnt` advances only when `out_ready`=1.
  - `col_ld`=RUN & `byte_idx`==0 & `out_ready`, so a stalled column is loaded once, when `out_ready` rises.
  - d0..d3 are held throughout a stall.
  - DONE is entered only after slot 15 completes with `out_ready`=1.
- `PTS_SEQ_STALL_EN` undefined:
  - No `out_ready` port.
  - Fixed 16-cycle RUN as described above.

## Test plan
- Reset, then block 0x00112233_44556677_8899aabb_ccddeeff with `in_valid` held:
  - `col_ld` pulses at +1, +5, +9, +13.
  - d0..d3 = 00/11/22/33, 44/55/66/77, 88/99/aa/bb, cc/dd/ee/ff.
  - `done` at +17.
- Two blocks back-to-back (second block = 0x01…): second `col_ld` arrives 17 cycles after the first; d0..d3 = 01,11,22,33 in column 0 of the second block.
- `abort` at column 2, `byte_idx` 1:
  - No further `col_ld`, no `done`.
  - `in_ready`=1 the next cycle.
  - A new block then starts cleanly at column 0.
- `rst` pulsed low mid-RUN:
  - Outputs go to 0 asynchronously.
  - `in_ready`=0 until the first edge after release, then 1.
- `abort` and `in_valid` asserted in the same IDLE cycle: nothing accepted; `busy` stays 0.
- (`PTS_SEQ_STALL_EN`) `out_ready`=0 for 3 cycles at column 1, slot 0:
  - Exactly one `col_ld` for column 1, when `out_ready` rises.
  - d0..d3 = 44/55/66/77 held throughout the stall.
  - `done` is delayed by 3 cycles to +20.

Source files
------------

// File: rtl/pts_sequencer.sv
// rtl/pts_sequencer.sv - 128-bit block to four-column converter sequencer (optional stall: PTS_SEQ_STALL_EN)
module pts_sequencer (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   input  logic         abort,
`ifdef PTS_SEQ_STALL_EN
   input  logic         out_ready,
`endif
   output logic         col_ld,
   output logic [7:0]   d0,
   output logic [7:0]   d1,
   output logic [7:0]   d2,
   output logic [7:0]   d3,
   output logic [1:0]   col_idx,
   output logic [1:0]   byte_idx,
   output logic         busy,
   output logic         done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t         state;
   state_t         state_n;
   logic [3:0]     cnt;
   logic [3:0]     cnt_n;
   logic [127:0]   blk;
   logic [127:0]   blk_n;
   logic           advance;
   logic           handshake;
   logic           col_first;
   logic           col_first_n;

`ifdef PTS_SEQ_STALL_EN
   assign advance = out_ready;
`else
   assign advance = 1'b1;
`endif

   // abort always beats a pending block; in_ready is only high in IDLE/DONE
   assign handshake = in_valid & in_ready & ~abort;

   // byte 0 is the MSB of the block, so column c starts at bit 127-32c
   function automatic logic [31:0] column_of(input logic [127:0] b, input logic [1:0] c);
      logic [31:0] w;
      case (c)
         2'd0:    w = b[127:96];
         2'd1:    w = b[95:64];
         2'd2:    w = b[63:32];
         default: w = b[31:0];
      endcase
      return w;
   endfunction

   // next-state, slot counter and block capture
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      blk_n   = blk;
      case (state)
         S_IDLE: begin
            if (handshake) begin
               blk_n   = in_data;
               cnt_n   = 4'd0;
               state_n = S_RUN;
            end
         end
         S_RUN: begin
            if (abort) begin
               cnt_n   = 4'd0;
               state_n = S_IDLE;
            end else if (advance) begin
               cnt_n = cnt + 4'd1;
               if (cnt == 4'd15) begin
                  state_n = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (handshake) begin
               blk_n   = in_data;
               cnt_n   = 4'd0;
               state_n = S_RUN;
            end else begin
               state_n = S_IDLE;
            end
         end
         default: begin
            cnt_n   = 4'd0;
            state_n = S_IDLE;
         end
      endcase
   end

   assign col_first_n = (state_n == S_RUN) && (cnt_n[1:0] == 2'd0);

   // state register, counter and captured block
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
         cnt   <= 4'd0;
         blk   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         blk   <= blk_n;
      end
   end

   // registered outputs, decoded from the next state so they line up with it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_ready  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         col_idx   <= 2'd0;
         byte_idx  <= 2'd0;
         col_first <= 1'b0;
         d0        <= 8'd0;
         d1        <= 8'd0;
         d2        <= 8'd0;
         d3        <= 8'd0;
      end else begin
         in_ready  <= (state_n != S_RUN);
         busy      <= (state_n == S_RUN);
         done      <= (state_n == S_DONE);
         col_idx   <= cnt_n[3:2];
         byte_idx  <= cnt_n[1:0];
         col_first <= col_first_n;
         // the column bytes change only on entry to a column's first slot and
         // are otherwise held, including across an abort or a stall
         if (col_first_n) begin
            {d0, d1, d2, d3} <= column_of(blk_n, cnt_n[3:2]);
         end
      end
   end

`ifdef PTS_SEQ_STALL_EN
   // a stalled first slot strobes the converter only once the sink is ready
   assign col_ld = col_first & out_ready;
`else
   assign col_ld = col_first;
`endif

endmodule

// File: tb/tb_pts_sequencer.sv
// tb/tb_pts_sequencer.sv - table-driven bench for pts_sequencer
module tb_pts_sequencer;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [127:0] in_data = '0;
   logic         abort = 1'b0;
`ifdef PTS_SEQ_STALL_EN
   logic         out_ready = 1'b1;
`endif
   logic         col_ld;
   logic [7:0]   d0, d1, d2, d3;
   logic [1:0]   col_idx, byte_idx;
   logic         busy, done;

   localparam logic [127:0] BLK_A = 128'h00112233_44556677_8899aabb_ccddeeff;
   localparam logic [127:0] BLK_B = 128'h01112233_44556677_8899aabb_ccddeeff;
   localparam logic [127:0] BLK_C = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
   localparam logic [127:0] BLK_D = 128'ha0a1a2a3_b0b1b2b3_c0c1c2c3_d0d1d2d3;
   localparam logic [127:0] JUNK  = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;

   pts_sequencer dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .abort(abort),
`ifdef PTS_SEQ_STALL_EN
      .out_ready(out_ready),
`endif
      .col_ld(col_ld),
      .d0(d0),
      .d1(d1),
      .d2(d2),
      .d3(d3),
      .col_idx(col_idx),
      .byte_idx(byte_idx),
      .busy(busy),
      .done(done)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic         iv;
      logic         ab;
      logic [127:0] data;
      logic         ld;
      logic [31:0]  d;
      logic [1:0]   col;
      logic [1:0]   byt;
      logic         busy;
      logic         done;
      logic         rdy;
   } vec_t;

   vec_t        tbl [0:127];
   int          n_rows = 0;
   logic [31:0] last_d = 32'd0;

   function automatic logic [31:0] column_of(input logic [127:0] b, input int c);
      return b[127-32*c -: 32];
   endfunction

   task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s row=%0d actual=%h expected=%h", nm, row, act, exp);
      end
   endtask

   task automatic push(input logic iv, input logic ab, input logic [127:0] data,
                       input logic ld, input logic [31:0] d, input logic [1:0] col,
                       input logic [1:0] byt, input logic bsy, input logic dn, input logic rdy);
      tbl[n_rows].iv   = iv;
      tbl[n_rows].ab   = ab;
      tbl[n_rows].data = data;
      tbl[n_rows].ld   = ld;
      tbl[n_rows].d    = d;
      tbl[n_rows].col  = col;
      tbl[n_rows].byt  = byt;
      tbl[n_rows].busy = bsy;
      tbl[n_rows].done = dn;
      tbl[n_rows].rdy  = rdy;
      n_rows++;
   endtask

   // RUN cycles t=1..nrows after a handshake; in_data is junk to show it is ignored
   task automatic add_run(input logic [127:0] b, input int nrows, input int abort_at);
      for (int t = 1; t <= nrows; t++) begin
         int c;
         int s;
         c = (t - 1) / 4;
         s = (t - 1) % 4;
         last_d = column_of(b, c);
         push(1'b1, (t == abort_at), JUNK, (s == 0), last_d, 2'(c), 2'(s), 1'b1, 1'b0, 1'b0);
      end
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_ready"}, -1, {31'd0, in_ready}, 32'd0);
      chk({nm, "_col_ld"}, -1, {31'd0, col_ld}, 32'd0);
      chk({nm, "_d"}, -1, {d0, d1, d2, d3}, 32'd0);
      chk({nm, "_col_idx"}, -1, {30'd0, col_idx}, 32'd0);
      chk({nm, "_byte_idx"}, -1, {30'd0, byte_idx}, 32'd0);
      chk({nm, "_busy"}, -1, {31'd0, busy}, 32'd0);
      chk({nm, "_done"}, -1, {31'd0, done}, 32'd0);
   endtask

   initial begin
      // reset state, asserted asynchronously before any clock edge
      #1 rst = 1'b0;
      #2 chk_all_zero("reset");
      @(negedge clk);
      @(negedge clk);
      chk_all_zero("reset_held");

      // block A with in_valid held, B back-to-back, C aborted, abort-vs-valid, D clean
      push(1'b1, 1'b0, BLK_A, 1'b0, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      push(1'b1, 1'b0, BLK_A, 1'b0, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
      add_run(BLK_A, 16, 0);
      push(1'b1, 1'b0, BLK_B, 1'b0, last_d, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1);
      add_run(BLK_B, 16, 0);
      push(1'b0, 1'b0, JUNK, 1'b0, last_d, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1);
      push(1'b0, 1'b0, JUNK, 1'b0, last_d, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
      push(1'b1, 1'b0, BLK_C, 1'b0, last_d, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
      add_run(BLK_C, 10, 10);
      push(1'b0, 1'b0, JUNK, 1'b0, last_d, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
      push(1'b0, 1'b0, JUNK, 1'b0, last_d, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
      push(1'b1, 1'b1, BLK_D, 1'b0, last_d, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
      push(1'b0, 1'b0, JUNK, 1'b0, last_d, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
      push(1'b1, 1'b0, BLK_D, 1'b0, last_d, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
      add_run(BLK_D, 16, 0);
      push(1'b0, 1'b0, JUNK, 1'b0, last_d, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1);
      push(1'b0, 1'b0, JUNK, 1'b0, last_d, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);

      rst = 1'b1;
      for (int i = 0; i < n_rows; i++) begin
         if (i > 0) @(negedge clk);
         in_valid = tbl[i].iv;
         abort    = tbl[i].ab;
         in_data  = tbl[i].data;
         #1;
         chk("in_ready", i, {31'd0, in_ready}, {31'd0, tbl[i].rdy});
         chk("col_ld", i, {31'd0, col_ld}, {31'd0, tbl[i].ld});
         chk("d0_d3", i, {d0, d1, d2, d3}, tbl[i].d);
         chk("col_idx", i, {30'd0, col_idx}, {30'd0, tbl[i].col});
         chk("byte_idx", i, {30'd0, byte_idx}, {30'd0, tbl[i].byt});
         chk("busy", i, {31'd0, busy}, {31'd0, tbl[i].busy});
         chk("done", i, {31'd0, done}, {31'd0, tbl[i].done});
      end

      // reset pulsed mid-RUN, at column 1 slot 0
      @(negedge clk);
      in_valid = 1'b1;
      abort    = 1'b0;
      in_data  = BLK_A;
      #1 chk("mid_rst_ready", -1, {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("mid_rst_pre_ld", -1, {31'd0, col_ld}, 32'd1);
      chk("mid_rst_pre_col", -1, {30'd0, col_idx}, 32'd1);
      chk("mid_rst_pre_d", -1, {d0, d1, d2, d3}, 32'h44556677);
      #2 rst = 1'b0;
      #1 chk_all_zero("mid_rst");
      @(negedge clk);
      chk_all_zero("mid_rst_held");
      rst = 1'b1;
      #1 chk("rst_release_ready", -1, {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      chk("rst_first_edge_ready", -1, {31'd0, in_ready}, 32'd1);
      chk("rst_first_edge_busy", -1, {31'd0, busy}, 32'd0);

`ifdef PTS_SEQ_STALL_EN
      // three-cycle stall at column 1 slot 0
      begin
         int t;
         int ld_col1;
         int done_at;
         ld_col1 = 0;
         done_at = -1;
         in_valid = 1'b1;
         in_data  = BLK_A;
         @(negedge clk);
         in_valid = 1'b0;
         in_data  = JUNK;
         for (t = 1; t <= 30; t++) begin
            if (t > 1) @(negedge clk);
            out_ready = !(t >= 5 && t <= 7);
            #1;
            if (done) begin
               done_at = t;
               break;
            end
            if (col_ld && col_idx == 2'd1) ld_col1++;
            if (t >= 5 && t <= 8) begin
               chk("stall_d", t, {d0, d1, d2, d3}, 32'h44556677);
               chk("stall_col", t, {30'd0, col_idx}, 32'd1);
               chk("stall_byte", t, {30'd0, byte_idx}, 32'd0);
               chk("stall_ld", t, {31'd0, col_ld}, (t == 8) ? 32'd1 : 32'd0);
            end
         end
         out_ready = 1'b1;
         chk("stall_ld_count", -1, ld_col1, 32'd1);
         chk("stall_done_at", -1, done_at, 32'd20);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
